// File: rtl/register_bank_pkg.sv
// Shared error codes for the register bank and its address decoder.
package register_bank_pkg;

  localparam int ERR_CODE_W = 4;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_OK       = 4'd0,
    ERR_RD_RANGE = 4'd1,
    ERR_WR_RANGE = 4'd2,
    ERR_WR_RO    = 4'd3
  } error_code_t;

endpackage

// File: rtl/register_bank_addr_decoder.sv
// Address decoder: classifies an address as read-only / in range and yields its fault code.
// Purely combinational, zero latency, no backpressure.
module reg_addr_decoder
  import register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEMORY_SIZE = 255,
  parameter int RO_COUNT    = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  is_write,
  output logic                  is_ro,
  output logic                  in_range,
  output error_code_t           err
);

  // One extra bit so MEMORY_SIZE == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] RO_LIMIT  = (ADDR_WIDTH+1)'(RO_COUNT);

  always_comb begin
    in_range = ({1'b0, addr} < MEM_LIMIT);
    is_ro    = ({1'b0, addr} < RO_LIMIT);
    err      = ERR_OK;
    if (is_write) begin
      if (!in_range)  err = ERR_WR_RANGE;
      else if (is_ro) err = ERR_WR_RO;
    end else if (!in_range) begin
      err = ERR_RD_RANGE;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register bank: strobed writes, read-only status window, registered reads (1-cycle latency).
// Accepts a read and a write every cycle; no backpressure.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    MEMORY_SIZE = 255,
  parameter int                    RO_COUNT    = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          reg_addr,
  input  logic [RO_COUNT*DATA_WIDTH-1:0] ro_data,
  input  logic                           err_clear,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           rd_valid,
  output logic [ERR_CODE_W-1:0]          error_code,
  output logic                           error_sticky
);

  localparam int RW_COUNT = MEMORY_SIZE - RO_COUNT;
  localparam int IDX_W    = (RW_COUNT > 1) ? $clog2(RW_COUNT) : 1;
  localparam int LANES    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] RO_BASE = ADDR_WIDTH'(RO_COUNT);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("register_bank: DATA_WIDTH must be a multiple of 8");
  end
  if (MEMORY_SIZE > (2 ** ADDR_WIDTH)) begin : g_chk_ms
    $error("register_bank: MEMORY_SIZE exceeds the address space");
  end
  if (RO_COUNT < 1 || RO_COUNT >= MEMORY_SIZE) begin : g_chk_ro
    $error("register_bank: RO_COUNT must be in [1, MEMORY_SIZE)");
  end

  logic [DATA_WIDTH-1:0] mem [RW_COUNT];

  logic        rd_is_ro, rd_in_range;
  logic        wr_is_ro, wr_in_range;
  error_code_t rd_err, wr_err, txn_err;

  reg_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEMORY_SIZE(MEMORY_SIZE),
    .RO_COUNT   (RO_COUNT)
  ) u_rd_dec (
    .addr    (reg_addr),
    .is_write(1'b0),
    .is_ro   (rd_is_ro),
    .in_range(rd_in_range),
    .err     (rd_err)
  );

  reg_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEMORY_SIZE(MEMORY_SIZE),
    .RO_COUNT   (RO_COUNT)
  ) u_wr_dec (
    .addr    (wr_addr),
    .is_write(1'b1),
    .is_ro   (wr_is_ro),
    .in_range(wr_in_range),
    .err     (wr_err)
  );

  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  wr_ok, txn_active;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_idx     = IDX_W'(reg_addr - RO_BASE);
  assign wr_idx     = IDX_W'(wr_addr - RO_BASE);
  assign wr_ok      = wr_en && wr_in_range && !wr_is_ro;
  assign txn_active = rd_en || wr_en;

  // Write faults (3, 2) always outrank the only read fault (1).
  always_comb begin
    txn_err = ERR_OK;
    if (wr_en && wr_err != ERR_OK)      txn_err = wr_err;
    else if (rd_en && rd_err != ERR_OK) txn_err = rd_err;
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (rd_is_ro) begin
        for (int k = 0; k < RO_COUNT; k++) begin
          if (reg_addr == ADDR_WIDTH'(k)) rd_word = ro_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        rd_word = mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RW_COUNT; i++) mem[i] <= RESET_VALUE;
    end else if (wr_ok) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read data is captured from the pre-edge array contents, giving read-first collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data    <= '0;
      rd_valid     <= 1'b0;
      error_code   <= ERR_OK;
      error_sticky <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)      read_data  <= rd_word;
      if (txn_active) error_code <= txn_err;
      if (txn_active && txn_err != ERR_OK) error_sticky <= 1'b1;
      else if (err_clear)                  error_sticky <= 1'b0;
    end
  end

endmodule
